frame_writer: RTL and testbench

// - Drains the sobel output FIFO (almost-empty/read/data handshake) and writes pixels into a

---
 rtl/frame_writer_pkg.sv | 22 ++
 rtl/frame_writer.sv | 144 ++++++++++++++
 tb/tb_frame_writer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : frame_writer_pkg
// Purpose  : Shared constants and FSM encoding for the frame writer.
// Revision : 1.0 - initial release
// ============================================================================
package frame_writer_pkg;

    // Display raster geometry; one bank holds exactly one frame.
    localparam int unsigned FRAME_W            = 640;
    localparam int unsigned FRAME_H            = 480;
    localparam int unsigned BRAM_DEPTH_DEFAULT = FRAME_W * FRAME_H;

    // Writer control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fw_state_e;

endpackage : frame_writer_pkg
`default_nettype wire

// File: rtl/frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : frame_writer
// Purpose  : Drains the sobel output FIFO and writes pixels into a ping-pong
//            frame buffer. Banks flip only on complete frames, so the display
//            side never reads a torn frame.
// Revision : 1.0 - initial release
// ============================================================================
module frame_writer
    import frame_writer_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int BRAM_DEPTH = BRAM_DEPTH_DEFAULT,
    parameter int ADDR_W     = 19
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_flush,
    input  logic                  i_almostempty,
    output logic                  o_rd,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  o_we,
    output logic [ADDR_W:0]       o_waddr,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic                  o_disp_bank,
    output logic                  o_frame_done,
    output logic [7:0]            o_frame_cnt
);

    // Last bank-local address of a frame; pix never carries into the bank bit.
    localparam logic [ADDR_W-1:0] c_LAST_PIX = ADDR_W'(BRAM_DEPTH - 1);

    fw_state_e             state_q, state_d;
    logic                  rd_q, rd_d;
    logic                  rd_d1_q, rd_d1_d;
    logic                  we_q, we_d;
    logic [ADDR_W:0]       waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0]     pix_q, pix_d;
    logic                  wbank_q, wbank_d;
    logic                  disp_bank_q, disp_bank_d;
    logic                  wrap_q, wrap_d;
    logic                  frame_done_q, frame_done_d;
    logic [7:0]            frame_cnt_q, frame_cnt_d;

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush dominates every other transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!i_flush) state_d = ST_RUN;
            ST_RUN:   if (i_flush)  state_d = ST_FLUSH;
            ST_FLUSH: if (!i_flush) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Read pipeline, pixel addressing and bank flip on the last pixel of a frame.
    always_comb begin
        rd_d         = 1'b0;
        rd_d1_d      = 1'b0;
        we_d         = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        pix_d        = pix_q;
        wbank_d      = wbank_q;
        disp_bank_d  = disp_bank_q;
        wrap_d       = 1'b0;
        frame_done_d = wrap_q;
        frame_cnt_d  = frame_cnt_q;

        if (state_q == ST_RUN && !i_flush) begin
            rd_d    = ~i_almostempty;
            rd_d1_d = rd_q;
            // Data requested two cycles ago is on i_rdata now.
            if (rd_d1_q) begin
                we_d    = 1'b1;
                wdata_d = i_rdata;
                waddr_d = {wbank_q, pix_q};
                if (pix_q == c_LAST_PIX) begin
                    pix_d       = '0;
                    wbank_d     = ~wbank_q;
                    disp_bank_d = wbank_q;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    wrap_d      = 1'b1;
                end else begin
                    pix_d = pix_q + ADDR_W'(1);
                end
            end
        end

        // A flushed partial frame restarts at pixel 0 of the same bank.
        if (i_flush) begin
            pix_d = '0;
        end
    end

    // Datapath registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_q         <= 1'b0;
            rd_d1_q      <= 1'b0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            pix_q        <= '0;
            wbank_q      <= 1'b0;
            disp_bank_q  <= 1'b1;
            wrap_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= 8'd0;
        end else begin
            rd_q         <= rd_d;
            rd_d1_q      <= rd_d1_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            pix_q        <= pix_d;
            wbank_q      <= wbank_d;
            disp_bank_q  <= disp_bank_d;
            wrap_q       <= wrap_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign o_rd         = rd_q;
    assign o_we         = we_q;
    assign o_waddr      = waddr_q;
    assign o_wdata      = wdata_q;
    assign o_disp_bank  = disp_bank_q;
    assign o_frame_done = frame_done_q;
    assign o_frame_cnt  = frame_cnt_q;

endmodule : frame_writer
`default_nettype wire

// File: tb/tb_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_writer
// Purpose  : Directed self-checking bench for frame_writer. Two instances run
//            side by side: 16-pixel frames and 4-pixel frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_writer;

    localparam int DW = 12;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          i_flush = 1'b0;
    logic          i_almostempty = 1'b1;
    logic [DW-1:0] i_rdata = '0;

    logic          rd16, we16, disp16, done16;
    logic [5:0]    waddr16;
    logic [DW-1:0] wdata16;
    logic [7:0]    cnt16;

    logic          rd4, we4, disp4, done4;
    logic [3:0]    waddr4;
    logic [DW-1:0] wdata4;
    logic [7:0]    cnt4;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int data_ctr = 1;
    logic take;

    logic [5:0]    wa16_q[$];
    logic [DW-1:0] wd16_q[$];
    int            wc16_q[$];
    int            done16_cyc_q[$];
    int            rd16_n = 0;
    int            first_rd_cyc = -1;
    logic          disp4_at[$];
    logic [7:0]    cnt4_at[$];

    frame_writer #(.DATA_WIDTH(DW), .BRAM_DEPTH(16), .ADDR_W(5)) dut16 (
        .CLK(CLK), .RST(RST), .i_flush(i_flush), .i_almostempty(i_almostempty),
        .o_rd(rd16), .i_rdata(i_rdata), .o_we(we16), .o_waddr(waddr16),
        .o_wdata(wdata16), .o_disp_bank(disp16), .o_frame_done(done16),
        .o_frame_cnt(cnt16)
    );

    frame_writer #(.DATA_WIDTH(DW), .BRAM_DEPTH(4), .ADDR_W(3)) dut4 (
        .CLK(CLK), .RST(RST), .i_flush(i_flush), .i_almostempty(i_almostempty),
        .o_rd(rd4), .i_rdata(i_rdata), .o_we(we4), .o_waddr(waddr4),
        .o_wdata(wdata4), .o_disp_bank(disp4), .o_frame_done(done4),
        .o_frame_cnt(cnt4)
    );

    always #4 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    // Upstream FIFO model: data appears one cycle after a sampled read strobe.
    always begin
        @(negedge CLK);
        take = rd16;
        @(posedge CLK);
        #1;
        if (take) begin
            i_rdata = DW'(data_ctr);
            data_ctr++;
        end
    end

    // Write / event logger.
    always @(negedge CLK) begin
        if (RST === 1'b1) begin
            if (we16) begin
                wa16_q.push_back(waddr16);
                wd16_q.push_back(wdata16);
                wc16_q.push_back(cyc);
            end
            if (done16) done16_cyc_q.push_back(cyc);
            if (rd16) begin
                if (rd16_n == 0) first_rd_cyc = cyc;
                rd16_n++;
            end
            if (done4) begin
                disp4_at.push_back(disp4);
                cnt4_at.push_back(cnt4);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        wa16_q.delete();
        wd16_q.delete();
        wc16_q.delete();
        done16_cyc_q.delete();
        disp4_at.delete();
        cnt4_at.delete();
        rd16_n       = 0;
        first_rd_cyc = -1;
        data_ctr     = 1;
        i_rdata      = '0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b0;
        i_flush = 1'b0;
        i_almostempty = 1'b1;
        repeat (2) @(negedge CLK);
        clear_logs();
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic wait_writes(input int n, input string nm);
        int k = 0;
        while (wa16_q.size() < n && k < 300) begin
            @(negedge CLK);
            #1;
            k++;
        end
        tests++;
        if (wa16_q.size() < n) begin
            fails++;
            $display("FAIL %s timeout: got %0d writes, need %0d", nm, wa16_q.size(), n);
        end
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RST = 1'b0;
        i_almostempty = 1'b0;
        i_flush = 1'b0;
        repeat (3) @(negedge CLK);
        tests++; if (rd16 !== 1'b0)      begin fails++; $display("FAIL rst_rd: got %b want 0", rd16); end
        tests++; if (we16 !== 1'b0)      begin fails++; $display("FAIL rst_we: got %b want 0", we16); end
        tests++; if (waddr16 !== 6'd0)   begin fails++; $display("FAIL rst_waddr: got %h want 0", waddr16); end
        tests++; if (wdata16 !== '0)     begin fails++; $display("FAIL rst_wdata: got %h want 0", wdata16); end
        tests++; if (disp16 !== 1'b1)    begin fails++; $display("FAIL rst_disp: got %b want 1", disp16); end
        tests++; if (done16 !== 1'b0)    begin fails++; $display("FAIL rst_done: got %b want 0", done16); end
        tests++; if (cnt16 !== 8'd0)     begin fails++; $display("FAIL rst_cnt: got %0d want 0", cnt16); end
        clear_logs();
        RST = 1'b1;
        @(negedge CLK);
        tests++; if (rd16 !== 1'b0) begin fails++; $display("FAIL rst_rd_lag: got %b want 0", rd16); end
        @(negedge CLK);
        tests++; if (rd16 !== 1'b1) begin fails++; $display("FAIL first_rd: got %b want 1", rd16); end
    endtask

    task automatic test_stream();
        wait_writes(3, "stream_wait");
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (wa16_q[i] !== 6'(i) || wd16_q[i] !== DW'(i + 1)) begin
                fails++;
                $display("FAIL stream_word%0d: got addr %h data %h want addr %h data %h",
                         i, wa16_q[i], wd16_q[i], 6'(i), DW'(i + 1));
            end
        end
        tests++;
        if (wc16_q[0] - first_rd_cyc !== 2) begin
            fails++;
            $display("FAIL rd_to_we_latency: got %0d want 2", wc16_q[0] - first_rd_cyc);
        end
        tests++;
        if (wc16_q[2] - wc16_q[0] !== 2) begin
            fails++;
            $display("FAIL stream_rate: got %0d cycles for 3 words want 2", wc16_q[2] - wc16_q[0]);
        end
    endtask

    task automatic test_frame_wrap();
        wait_writes(18, "wrap_wait");
        tests++; if (wa16_q[15] !== 6'd15) begin fails++; $display("FAIL wrap_last_addr: got %h want 0f", wa16_q[15]); end
        tests++; if (wa16_q[16] !== 6'd32) begin fails++; $display("FAIL wrap_next_addr: got %h want 20", wa16_q[16]); end
        tests++; if (wd16_q[16] !== DW'(17)) begin fails++; $display("FAIL wrap_next_data: got %h want 011", wd16_q[16]); end
        tests++; if (done16_cyc_q.size() !== 1) begin fails++; $display("FAIL wrap_done_count: got %0d want 1", done16_cyc_q.size()); end
        tests++;
        if (done16_cyc_q[0] !== wc16_q[15] + 1) begin
            fails++;
            $display("FAIL wrap_done_cycle: got %0d want %0d", done16_cyc_q[0], wc16_q[15] + 1);
        end
        tests++; if (disp16 !== 1'b0) begin fails++; $display("FAIL wrap_disp: got %b want 0", disp16); end
        tests++; if (cnt16 !== 8'd1) begin fails++; $display("FAIL wrap_cnt: got %0d want 1", cnt16); end
    endtask

    task automatic test_stall();
        int viol = 0;
        int bad  = 0;
        int n;
        logic [5:0] ea;
        do_reset();
        for (int c = 0; c < 60; c++) begin
            @(negedge CLK);
            if (rd16 && i_almostempty) viol++;
            if (c % 3 == 0) i_almostempty = ~i_almostempty;
        end
        i_almostempty = 1'b1;
        repeat (6) @(negedge CLK);
        #1;
        n = wa16_q.size();
        tests++; if (viol !== 0) begin fails++; $display("FAIL stall_rd_high: got %0d violations want 0", viol); end
        tests++; if (n !== rd16_n) begin fails++; $display("FAIL stall_count: got %0d writes want %0d reads", n, rd16_n); end
        tests++; if (n < 17) begin fails++; $display("FAIL stall_volume: got %0d writes want >=17", n); end
        for (int k = 0; k < n; k++) begin
            ea = 6'(((k / 16) % 2) * 32 + (k % 16));
            if (wa16_q[k] !== ea || wd16_q[k] !== DW'(k + 1)) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL stall_contiguous: got %0d bad words want 0", bad); end
    endtask

    task automatic test_flush();
        int  k = 0;
        int  nw;
        logic quiet = 1'b1;
        do_reset();
        i_almostempty = 1'b0;
        while (!(we16 && waddr16 == 6'd6) && k < 100) begin
            @(negedge CLK);
            k++;
        end
        tests++;
        if (!(we16 && waddr16 == 6'd6)) begin
            fails++;
            $display("FAIL flush_find_pix6: got we %b addr %h want we 1 addr 06", we16, waddr16);
        end
        #1;
        nw = wa16_q.size();
        i_flush = 1'b1;
        repeat (4) begin
            @(negedge CLK);
            if (rd16 !== 1'b0 || we16 !== 1'b0) quiet = 1'b0;
        end
        #1;
        tests++; if (quiet !== 1'b1) begin fails++; $display("FAIL flush_quiet: got rd/we activity want none"); end
        tests++; if (wa16_q.size() !== 7 || nw !== 7) begin fails++; $display("FAIL flush_discard: got %0d writes want 7", wa16_q.size()); end
        i_flush = 1'b0;
        wait_writes(8, "flush_resume_wait");
        tests++; if (wa16_q[7] !== 6'd0) begin fails++; $display("FAIL flush_resume_addr: got %h want 00", wa16_q[7]); end
        tests++; if (wd16_q[7] !== DW'(10)) begin fails++; $display("FAIL flush_resume_data: got %h want 00a", wd16_q[7]); end
        tests++; if (done16_cyc_q.size() !== 0) begin fails++; $display("FAIL flush_no_done: got %0d pulses want 0", done16_cyc_q.size()); end
        tests++; if (disp16 !== 1'b1) begin fails++; $display("FAIL flush_disp: got %b want 1", disp16); end
    endtask

    task automatic test_counter_wrap();
        int k = 0;
        int bad_disp = 0;
        int bad_cnt  = 0;
        do_reset();
        i_almostempty = 1'b0;
        while (disp4_at.size() < 256 && k < 3000) begin
            @(negedge CLK);
            #1;
            k++;
        end
        tests++;
        if (disp4_at.size() < 256) begin
            fails++;
            $display("FAIL cwrap_wait: got %0d frames want 256", disp4_at.size());
        end
        for (int i = 0; i < 256; i++) begin
            if (disp4_at[i] !== ((i % 2 == 0) ? 1'b0 : 1'b1)) bad_disp++;
            if (cnt4_at[i] !== 8'((i + 1) % 256)) bad_cnt++;
        end
        tests++; if (cnt4 !== 8'd0) begin fails++; $display("FAIL cwrap_cnt: got %0d want 0", cnt4); end
        tests++; if (cnt4_at[0] !== 8'd1) begin fails++; $display("FAIL cwrap_first_cnt: got %0d want 1", cnt4_at[0]); end
        tests++; if (bad_disp !== 0) begin fails++; $display("FAIL cwrap_disp_alt: got %0d bad frames want 0", bad_disp); end
        tests++; if (bad_cnt !== 0) begin fails++; $display("FAIL cwrap_cnt_seq: got %0d bad frames want 0", bad_cnt); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_frame_wrap();
        test_stall();
        test_flush();
        test_counter_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_frame_writer
`default_nettype wire
